// File: rtl/riscv_ex_mult_arbiter_pkg.sv
// Shared definitions for the EX-stage multiplier arbiter: FSM states and the multiplier operator encoding.
// Optional feature macro used by the arbiter files: RISCV_DIFT_TAG_EN.
package riscv_defines;

  localparam int MUL_OP_WIDTH = 3;

  localparam logic [MUL_OP_WIDTH-1:0] MUL_MAC32 = 3'b000;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_MSU32 = 3'b001;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_I     = 3'b010;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_IR    = 3'b011;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT8  = 3'b100;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT16 = 3'b101;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_H     = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ex_arb_state_t;

endpackage

// File: rtl/riscv_ex_mult_arbiter_if.sv
// Requester-side request/response bundle of the multiplier arbiter.
// RISCV_DIFT_TAG_EN adds per-requester operand taint tags and the response tag.
interface riscv_ex_mult_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = riscv_defines::MUL_OP_WIDTH
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][OP_WIDTH-1:0]   req_op_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_c_i;
  logic [NUM_REQ-1:0]                 rsp_valid_o;
  logic [NUM_REQ-1:0]                 rsp_ready_i;
  logic [DATA_WIDTH-1:0]              rsp_result_o;
  logic                               rsp_err_o;
`ifdef RISCV_DIFT_TAG_EN
  logic [NUM_REQ-1:0]                 req_a_tag_i;
  logic [NUM_REQ-1:0]                 req_b_tag_i;
  logic [NUM_REQ-1:0]                 req_c_tag_i;
  logic                               rsp_tag_o;
`endif

  modport master (
`ifdef RISCV_DIFT_TAG_EN
    output req_a_tag_i, req_b_tag_i, req_c_tag_i,
    input  rsp_tag_o,
`endif
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
  );

  modport slave (
`ifdef RISCV_DIFT_TAG_EN
    input  req_a_tag_i, req_b_tag_i, req_c_tag_i,
    output rsp_tag_o,
`endif
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
  );
endinterface

// File: rtl/riscv_ex_mult_arbiter_rr.sv
// Combinational round-robin picker: first request found searching upward from ptr_i+1 with wrap-around.
// Not affected by RISCV_DIFT_TAG_EN.
module riscv_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  // cand[k] is the requester with the k-th highest priority this cycle
  logic [IDX_W-1:0] cand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi + 1);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                      : sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any_o && req_i[cand[k]]) begin
        gnt_any_o        = 1'b1;
        gnt_o[cand[k]]   = 1'b1;
        gnt_idx_o        = cand[k];
      end
    end
  end

endmodule

// File: rtl/riscv_ex_mult_arbiter.sv
// Shares one iterative multiplier between NUM_REQ requesters with round-robin grant and a WAIT watchdog.
// Define RISCV_DIFT_TAG_EN to carry operand taint tags through to rsp_tag_o.
module riscv_ex_mult_arbiter
  import riscv_defines::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = MUL_OP_WIDTH,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_ex_mult_arbiter_if.slave req_bus,
  output logic                  res_en_o,
  output logic [OP_WIDTH-1:0]   res_op_o,
  output logic [DATA_WIDTH-1:0] res_a_o,
  output logic [DATA_WIDTH-1:0] res_b_o,
  output logic [DATA_WIDTH-1:0] res_c_o,
  input  logic                  res_ready_i,
  input  logic [DATA_WIDTH-1:0] res_result_i,
  output logic                  res_ex_ready_o,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  ex_arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]      ptr_reg, owner_reg, gnt_idx;
  logic [NUM_REQ-1:0]    gnt_onehot;
  logic                  gnt_any;
  logic [OP_WIDTH-1:0]   op_reg;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, c_reg, result_reg;
  logic                  err_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  timeout;
`ifdef RISCV_DIFT_TAG_EN
  logic                  tag_reg;
`endif

  riscv_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i     (req_bus.req_valid_i),
    .ptr_i     (ptr_reg),
    .gnt_o     (gnt_onehot),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign timeout = (MAX_WAIT != 0) && (cnt_reg == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next          = state_reg;
    req_bus.req_ready_o = '0;
    req_bus.rsp_valid_o = '0;
    res_en_o            = 1'b0;
    res_ex_ready_o      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_any) begin
          req_bus.req_ready_o = gnt_onehot;
          state_next          = WAIT;
        end
      end
      WAIT: begin
        res_en_o = 1'b1;
        // a result arriving on the timeout cycle still counts as a success
        if (res_ready_i) begin
          res_ex_ready_o = 1'b1;
          state_next     = RESP;
        end else if (timeout) begin
          state_next     = RESP;
        end
      end
      RESP: begin
        req_bus.rsp_valid_o[owner_reg] = 1'b1;
        if (req_bus.rsp_ready_i[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg    <= IDX_W'(NUM_REQ - 1);
      owner_reg  <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
`ifdef RISCV_DIFT_TAG_EN
      tag_reg    <= 1'b0;
`endif
    end else begin
      if (state_reg == IDLE && gnt_any) begin
        ptr_reg   <= gnt_idx;
        owner_reg <= gnt_idx;
        op_reg    <= req_bus.req_op_i[gnt_idx];
        a_reg     <= req_bus.req_a_i[gnt_idx];
        b_reg     <= req_bus.req_b_i[gnt_idx];
        c_reg     <= req_bus.req_c_i[gnt_idx];
`ifdef RISCV_DIFT_TAG_EN
        tag_reg   <= req_bus.req_a_tag_i[gnt_idx] | req_bus.req_b_tag_i[gnt_idx]
                   | req_bus.req_c_tag_i[gnt_idx];
`endif
      end
      if (state_reg == WAIT) begin
        if (res_ready_i) begin
          result_reg <= res_result_i;
          err_reg    <= 1'b0;
        end else if (timeout) begin
          result_reg <= '0;
          err_reg    <= 1'b1;
        end
      end
      if (state_reg == WAIT && state_next == WAIT) begin
        if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign res_op_o             = op_reg;
  assign res_a_o              = a_reg;
  assign res_b_o              = b_reg;
  assign res_c_o              = c_reg;
  assign req_bus.rsp_result_o = result_reg;
  assign req_bus.rsp_err_o    = err_reg;
  assign busy_o               = (state_reg != IDLE);
`ifdef RISCV_DIFT_TAG_EN
  // an aborted op has unknown provenance, so it is always reported tainted
  assign req_bus.rsp_tag_o    = tag_reg | err_reg;
`endif

endmodule

// File: tb/tb_riscv_ex_mult_arbiter.sv
// Scoreboard bench for riscv_ex_mult_arbiter with a small multiplier model; MAX_WAIT=4.
// Tag checks are active when RISCV_DIFT_TAG_EN is defined.
module tb_riscv_ex_mult_arbiter;
  import riscv_defines::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int OW = MUL_OP_WIDTH;
  localparam int MW = 4;

  typedef struct {
    int          owner;
    logic [31:0] result;
    logic        err;
    logic        tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          res_en_o, res_ready_i, res_ex_ready_o, busy_o;
  logic [OW-1:0] res_op_o;
  logic [DW-1:0] res_a_o, res_b_o, res_c_o, res_result_i;

  riscv_ex_mult_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW)) arb ();

  riscv_ex_mult_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .MAX_WAIT(MW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_bus        (arb),
    .res_en_o       (res_en_o),
    .res_op_o       (res_op_o),
    .res_a_o        (res_a_o),
    .res_b_o        (res_b_o),
    .res_c_o        (res_c_o),
    .res_ready_i    (res_ready_i),
    .res_result_i   (res_result_i),
    .res_ex_ready_o (res_ex_ready_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_gnt[$];
  rsp_t exp_rsp[$];
  int   gnt_seen = 0;
  int   mul_delay = 1;
  int   wait_cnt = 0;
  int   last_en_len = 0;
  int   ex_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, event never seen", name);
  endtask

  task automatic push_rsp(input int owner, input logic [31:0] result, input logic err, input logic tag);
    rsp_t r;
    r.owner = owner; r.result = result; r.err = err; r.tag = tag;
    exp_rsp.push_back(r);
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic at, input logic bt, input logic ct);
    arb.req_op_i[r] = MUL_MAC32;
    arb.req_a_i[r]  = a;
    arb.req_b_i[r]  = b;
    arb.req_c_i[r]  = '0;
`ifdef RISCV_DIFT_TAG_EN
    arb.req_a_tag_i[r] = at;
    arb.req_b_tag_i[r] = bt;
    arb.req_c_tag_i[r] = ct;
`else
    if (at | bt | ct) ;
`endif
  endtask

  // Leaves the caller at the negedge after the grant, with all requests dropped.
  task automatic wait_grants(input int n, input string name);
    int base;
    bit got;
    base = gnt_seen - n;
    got  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #3;
      if (gnt_seen >= base + n + n) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) fail_now(name);
    @(negedge clk);
    arb.req_valid_i = '0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #4;
      if (exp_rsp.size() == 0 && !busy_o) begin got = 1'b1; break; end
    end
    if (!got) fail_now(name);
  endtask

  // Multiplier model: result a*b+c in the mul_delay-th enabled cycle.
  initial begin
    res_ready_i  = 1'b0;
    res_result_i = '0;
    forever begin
      @(negedge clk);
      if (res_en_o) begin
        wait_cnt++;
        if (wait_cnt == mul_delay) begin
          res_ready_i  = 1'b1;
          res_result_i = res_a_o * res_b_o + res_c_o;
        end else begin
          res_ready_i  = 1'b0;
          res_result_i = '0;
        end
      end else begin
        if (wait_cnt != 0) last_en_len = wait_cnt;
        wait_cnt     = 0;
        res_ready_i  = 1'b0;
        res_result_i = '0;
      end
      #1;
      if (res_ex_ready_o) ex_cnt++;
    end
  end

  // Monitor: grants and response handshakes are popped from the scoreboard queues.
  initial begin
    int   idx;
    int   e;
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (|arb.req_ready_o) begin
        idx = arb.req_ready_o[1] ? 1 : 0;
        check("grant_onehot", 64'($countones(arb.req_ready_o)), 64'd1);
        if (exp_gnt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_grant: got requester %0d expected none", idx);
        end else begin
          e = exp_gnt.pop_front();
          check("grant_idx", 64'(idx), 64'(e));
          $display("grant  : requester %0d (expected %0d)", idx, e);
        end
        gnt_seen++;
      end
      if (|(arb.rsp_valid_o & arb.rsp_ready_i)) begin
        idx = arb.rsp_valid_o[1] ? 1 : 0;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got owner %0d result %0h expected none", idx, arb.rsp_result_o);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_owner", 64'(idx), 64'(r.owner));
          check("rsp_result", 64'(arb.rsp_result_o), 64'(r.result));
          check("rsp_err", 64'(arb.rsp_err_o), 64'(r.err));
`ifdef RISCV_DIFT_TAG_EN
          check("rsp_tag", 64'(arb.rsp_tag_o), 64'(r.tag));
`endif
          $display("rsp    : owner %0d result %0d err %0b (expected %0d/%0d/%0b)",
                   idx, arb.rsp_result_o, arb.rsp_err_o, r.owner, r.result, r.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ex_before;
    bit got;
    arb.req_valid_i = '0;
    arb.rsp_ready_i = '1;
    for (int r = 0; r < N; r++) set_req(r, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // reset state
    repeat (2) @(negedge clk);
    #3;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_res_en", 64'(res_en_o), 64'd0);
    check("rst_rsp_valid", 64'(arb.rsp_valid_o), 64'd0);
    check("rst_res_a", 64'(res_a_o), 64'd0);
    check("rst_result", 64'(arb.rsp_result_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single op 7*6, multiplier answers in its 3rd enabled cycle
    ex_cnt = 0; mul_delay = 3;
    exp_gnt.push_back(0); push_rsp(0, 32'd42, 1'b0, 1'b0);
    @(negedge clk);
    set_req(0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b01;
    wait_grants(1, "single_grant");
    #3;
    check("wait_res_en", 64'(res_en_o), 64'd1);
    check("wait_res_a", 64'(res_a_o), 64'd7);
    check("wait_res_b", 64'(res_b_o), 64'd6);
    check("wait_res_op", 64'(res_op_o), 64'(MUL_MAC32));
    check("wait_busy", 64'(busy_o), 64'd1);
    wait_done("single_rsp");
    check("ex_ready_pulses", 64'(ex_cnt), 64'd1);

    // requester 1 alone, 10*11
    mul_delay = 1;
    exp_gnt.push_back(1); push_rsp(1, 32'd110, 1'b0, 1'b0);
    @(negedge clk);
    set_req(1, 32'd10, 32'd11, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b10;
    wait_grants(1, "req1_grant");
    wait_done("req1_rsp");

    // fairness: both valid for 6 ops, 2*3 and 4*5
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(0); push_rsp(0, 32'd6, 1'b0, 1'b0);
      exp_gnt.push_back(1); push_rsp(1, 32'd20, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_req(0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    set_req(1, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b11;
    wait_grants(6, "fair_grants");
    wait_done("fair_rsp");

    // response backpressure; non-owner ready must be ignored
    exp_gnt.push_back(0); push_rsp(0, 32'd81, 1'b0, 1'b0);
    exp_gnt.push_back(1); push_rsp(1, 32'd12, 1'b0, 1'b0);
    @(negedge clk);
    arb.rsp_ready_i = 2'b10;
    set_req(0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    set_req(1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b11;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #3;
      if (arb.rsp_valid_o != '0) begin got = 1'b1; break; end
    end
    if (!got) fail_now("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(arb.rsp_valid_o), 64'd1);
      check("bp_result", 64'(arb.rsp_result_o), 64'd81);
      check("bp_busy", 64'(busy_o), 64'd1);
      check("bp_req_ready", 64'(arb.req_ready_o), 64'd0);
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    arb.rsp_ready_i = 2'b11;
    wait_grants(1, "bp_grant1");
    wait_done("bp_rsp");

    // watchdog abort: multiplier never answers
    ex_before = ex_cnt; mul_delay = 1000;
    exp_gnt.push_back(0); push_rsp(0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    set_req(0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b01;
    wait_grants(1, "wd_grant");
    wait_done("wd_rsp");
    check("wd_wait_cycles", 64'(last_en_len), 64'd4);
    check("wd_no_ex_ready", 64'(ex_cnt), 64'(ex_before));

    // ready on the timeout cycle wins
    mul_delay = 4;
    exp_gnt.push_back(0); push_rsp(0, 32'd144, 1'b0, 1'b0);
    @(negedge clk);
    set_req(0, 32'd12, 32'd12, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b01;
    wait_grants(1, "wd4_grant");
    wait_done("wd4_rsp");
    check("wd4_wait_cycles", 64'(last_en_len), 64'd4);

    // reset mid-WAIT drops the op; pointer returns to favour requester 0
    mul_delay = 1000;
    exp_gnt.push_back(0);
    @(negedge clk);
    set_req(0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b01;
    wait_grants(1, "rstw_grant");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("rstw_busy", 64'(busy_o), 64'd0);
    check("rstw_res_en", 64'(res_en_o), 64'd0);
    check("rstw_rsp_valid", 64'(arb.rsp_valid_o), 64'd0);
    check("rstw_res_a", 64'(res_a_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mul_delay = 1;
    exp_gnt.push_back(0); push_rsp(0, 32'd15, 1'b0, 1'b0);
    @(negedge clk);
    set_req(0, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    set_req(1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b11;
    wait_grants(1, "rstw_regrant");
    wait_done("rstw_rsp");

`ifdef RISCV_DIFT_TAG_EN
    // tag propagation: b tainted on requester 0, nothing tainted on requester 1
    exp_gnt.push_back(1); push_rsp(1, 32'd9, 1'b0, 1'b0);
    exp_gnt.push_back(0); push_rsp(0, 32'd4, 1'b0, 1'b1);
    @(negedge clk);
    set_req(0, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0);
    set_req(1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    arb.req_valid_i = 2'b11;
    wait_grants(2, "tag_grants");
    wait_done("tag_rsp");
`endif

    repeat (3) @(negedge clk);
    check("leftover_grants", 64'(exp_gnt.size()), 64'd0);
    check("leftover_rsps", 64'(exp_rsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_ex_mult_arbiter.md
Name: riscv_ex_mult_arbiter

Overview:
Shares one iterative multiplier datapath (the EX-stage MAC unit) between NUM_REQ requesters, e.g. the core EX pipe and an auxiliary accelerator port. It does round-robin arbitration and latches the winner's operands. It drives the multiplier through its enable/ready/ex_ready handshake, then returns the result to the winner over a valid/ready response channel. A watchdog aborts operations the multiplier never completes. It sits between the ID/EX operand muxes and the multiplier instance.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 3, multiplier operator width (matches the multiplier operator encoding)
MAX_WAIT, 64, watchdog limit in WAIT cycles; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  one-hot accept pulse
req_op_i  in  NUM_REQ x OP_WIDTH  multiplier operator
req_a_i / req_b_i / req_c_i  in  NUM_REQ x DATA_WIDTH  operands
rsp_valid_o  out  NUM_REQ  one-hot response valid, to the owning requester
rsp_ready_i  in  NUM_REQ  response accept
rsp_result_o  out  DATA_WIDTH  shared result bus, qualified by rsp_valid_o
rsp_err_o  out  1  watchdog abort flag, qualified by rsp_valid_o
res_en_o  out  1  multiplier enable
res_op_o  out  OP_WIDTH  operator to the multiplier
res_a_o / res_b_o / res_c_o  out  DATA_WIDTH  latched operands
res_ready_i  in  1  multiplier result ready
res_result_i  in  DATA_WIDTH  multiplier result
res_ex_ready_o  out  1  result-consumed strobe to the multiplier
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first. All outputs 0, including the latched operands and result. Reset mid-operation drops the in-flight op silently.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching upward from ptr+1 with wrap-around.
  - In the same cycle, req_ready_o[g]=1 (combinational). Latch op, a, b, c, owner id g. Set ptr<=g. Go to WAIT.
  - If no requests, stay in IDLE.
- WAIT:
  - res_en_o=1 with the latched op and operands held stable. The watchdog counter increments each cycle.
  - If res_ready_i=1: capture res_result_i, assert res_ex_ready_o=1 that cycle, set err=0, go to RESP.
  - Else if MAX_WAIT!=0 and cnt==MAX_WAIT-1: drop res_en_o next cycle, set result=0 and err=1, go to RESP. res_ex_ready_o stays 0.
  - If res_ready_i and the timeout occur in the same cycle, ready wins and err=0.
- RESP:
  - rsp_valid_o[owner]=1. rsp_result_o and rsp_err_o are held stable until rsp_ready_i[owner]=1.
  - On handshake go to IDLE. The counter clears on leaving WAIT.
  - rsp_ready_i bits of non-owners are ignored.
- Latency and throughput: accept at c0; WAIT from c1; if res_ready_i is set at c1, RESP at c2; IDLE at c3 after the rsp handshake. Max throughput is one op per 3 cycles.
- req_valid_i may drop before it is granted; no state change results. req_ready_o is 0 outside IDLE.
- Round-robin: after requester g is served, g has the lowest priority. Two continuously valid requesters therefore alternate 0,1,0,1.
- Counter width is clog2(MAX_WAIT+1) and it saturates. No other arithmetic is performed.

Optional Feature:
RISCV_DIFT_TAG_EN:
- When defined, adds per-requester tag inputs req_a_tag_i, req_b_tag_i and req_c_tag_i (NUM_REQ bits each), plus output rsp_tag_o.
- The tags are latched at accept.
- rsp_tag_o = a_tag | b_tag | c_tag, forced to 1 when err=1. It is qualified by rsp_valid_o and cleared to 0 on reset.
- When undefined, these ports and the tag registers are absent and behaviour is otherwise identical.

Decomposition:
- riscv_defines holds the FSM state typedef (ex_arb_state_t: IDLE/WAIT/RESP) and the multiplier operator width constant, so the operator width stays consistent with the multiplier.
- One sub-module: riscv_rr_arbiter. It is combinational: it takes the request vector and ptr, and returns a one-hot grant plus the encoded index.
- The top-level holds the FSM, the operand/result registers and the watchdog.

Test Plan:
- Reset state: rst=1 mid-WAIT → next cycle busy_o=0, res_en_o=0, all rsp_valid_o=0; after release, req_valid_i=2'b11 grants requester 0.
- Single op: req0 valid, op=MUL, a=7, b=6; multiplier ready 3 cycles after res_en_o → rsp_valid_o=2'b01 with result 42 and rsp_err_o=0; res_ex_ready_o is pulsed exactly once.
- Fairness: both requesters valid continuously for 6 ops → grant order 0,1,0,1,0,1.
- Response backpressure: rsp_ready_i held low for 5 cycles → result stable, no new req_ready_o, busy_o=1 throughout.
- Watchdog: MAX_WAIT=4, res_ready_i never set → after 4 WAIT cycles rsp_err_o=1 and result 0; with res_ready_i set on the 4th cycle instead → err=0 and the real result is returned.
- DIFT (RISCV_DIFT_TAG_EN): a_tag=0, b_tag=1 → rsp_tag_o=1; all tags 0 → 0; watchdog abort → 1.
